// File: rtl/multi_timer.sv
// Multi-channel compare timer on the simple-system bus: one 64-bit prescaled time base,
// NumChannels one-shot/periodic compare channels, W1C interrupt status with enable mask.
module multi_timer #(
    parameter int NumChannels  = 4,
    parameter int DataWidth    = 32,
    parameter int AddressWidth = 32
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    timer_req_i,
    input  logic                    timer_we_i,
    input  logic [3:0]              timer_be_i,
    input  logic [AddressWidth-1:0] timer_addr_i,
    input  logic [DataWidth-1:0]    timer_wdata_i,
    output logic                    timer_rvalid_o,
    output logic [DataWidth-1:0]    timer_rdata_o,
    output logic                    timer_err_o,
    output logic [NumChannels-1:0]  timer_intr_o,
    output logic                    timer_irq_o
);

    localparam logic [7:0] IDX_CTRL     = 8'd0;
    localparam logic [7:0] IDX_PRESCALE = 8'd1;
    localparam logic [7:0] IDX_MTIME_LO = 8'd2;
    localparam logic [7:0] IDX_MTIME_HI = 8'd3;
    localparam logic [7:0] IDX_INTR_ST  = 8'd4;
    localparam logic [7:0] IDX_INTR_EN  = 8'd5;

    function automatic logic [31:0] f_merge(input logic [31:0] old_v,
                                            input logic [31:0] new_v,
                                            input logic [3:0]  be);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[8*i +: 8] = be[i] ? new_v[8*i +: 8] : old_v[8*i +: 8];
        end
        return res;
    endfunction

    logic                   r_ctrl_en;
    logic [15:0]            r_prescale;
    logic [15:0]            r_pre_cnt;
    logic [63:0]            r_mtime;
    logic [NumChannels-1:0] r_intr_state;
    logic [NumChannels-1:0] r_intr_en;
    logic [63:0]            r_cmp    [NumChannels];
    logic [31:0]            r_period [NumChannels];
    logic [NumChannels-1:0] r_cfg_en;
    logic [NumChannels-1:0] r_cfg_per;
    logic                   r_rvalid;
    logic                   r_err;
    logic [DataWidth-1:0]   r_rdata;

    logic [7:0]             w_idx;
    logic                   w_chan_sel;
    logic [3:0]             w_ch;
    logic [1:0]             w_off;
    logic                   w_ch_ok;
    logic                   w_glob_ok;
    logic                   w_err;
    logic                   w_wr;
    logic [NumChannels-1:0] w_ch_hit;
    logic [NumChannels-1:0] w_cmp_lo_wr;
    logic [NumChannels-1:0] w_cmp_hi_wr;
    logic [NumChannels-1:0] w_period_wr;
    logic [NumChannels-1:0] w_cfg_wr;
    logic [NumChannels-1:0] w_fire;
    logic [NumChannels-1:0] w_w1c;
    logic [31:0]            w_bemask;
    logic [31:0]            w_clr;
    logic [31:0]            w_prescale_m;
    logic [31:0]            w_ie_m;
    logic                   w_tick;
    logic [DataWidth-1:0]   w_rdata;
    logic                   w_unused;

    // Word index from addr[9:2]; 0x100..0x1FF is the channel window, 16 bytes per channel.
    assign w_idx      = timer_addr_i[9:2];
    assign w_chan_sel = (w_idx[7:6] == 2'b01);
    assign w_ch       = w_idx[5:2];
    assign w_off      = w_idx[1:0];
    assign w_ch_ok    = w_chan_sel && (int'(w_ch) < NumChannels);
    assign w_glob_ok  = (w_idx <= IDX_INTR_EN);
    assign w_err      = !(w_glob_ok || w_ch_ok);
    assign w_wr       = timer_req_i && timer_we_i && !w_err && (|timer_be_i);

    assign w_bemask     = {{8{timer_be_i[3]}}, {8{timer_be_i[2]}},
                           {8{timer_be_i[1]}}, {8{timer_be_i[0]}}};
    assign w_clr        = timer_wdata_i & w_bemask;
    assign w_prescale_m = f_merge({16'h0, r_prescale}, timer_wdata_i, timer_be_i);
    assign w_ie_m       = f_merge({{(32-NumChannels){1'b0}}, r_intr_en}, timer_wdata_i, timer_be_i);
    assign w_w1c        = (w_wr && w_idx == IDX_INTR_ST) ? w_clr[NumChannels-1:0] : '0;
    assign w_tick       = r_ctrl_en && (r_pre_cnt == r_prescale);

    always_comb begin
        w_ch_hit    = '0;
        w_cmp_lo_wr = '0;
        w_cmp_hi_wr = '0;
        w_period_wr = '0;
        w_cfg_wr    = '0;
        w_fire      = '0;
        for (int c = 0; c < NumChannels; c++) begin
            w_ch_hit[c]    = w_ch_ok && (w_ch == 4'(c));
            w_cmp_lo_wr[c] = w_wr && w_ch_hit[c] && (w_off == 2'd0);
            w_cmp_hi_wr[c] = w_wr && w_ch_hit[c] && (w_off == 2'd1);
            w_period_wr[c] = w_wr && w_ch_hit[c] && (w_off == 2'd2);
            w_cfg_wr[c]    = w_wr && w_ch_hit[c] && (w_off == 2'd3) && timer_be_i[0];
            w_fire[c]      = r_cfg_en[c] && (r_mtime >= r_cmp[c]);
        end
    end

    always_comb begin
        w_rdata = '0;
        case (w_idx)
            IDX_CTRL:     w_rdata[0]             = r_ctrl_en;
            IDX_PRESCALE: w_rdata[15:0]          = r_prescale;
            IDX_MTIME_LO: w_rdata                = r_mtime[31:0];
            IDX_MTIME_HI: w_rdata                = r_mtime[63:32];
            IDX_INTR_ST:  w_rdata[NumChannels-1:0] = r_intr_state;
            IDX_INTR_EN:  w_rdata[NumChannels-1:0] = r_intr_en;
            default:      ;
        endcase
        for (int c = 0; c < NumChannels; c++) begin
            if (w_ch_hit[c]) begin
                case (w_off)
                    2'd0:    w_rdata = r_cmp[c][31:0];
                    2'd1:    w_rdata = r_cmp[c][63:32];
                    2'd2:    w_rdata = r_period[c];
                    default: w_rdata = {30'h0, r_cfg_per[c], r_cfg_en[c]};
                endcase
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            r_ctrl_en    <= 1'b0;
            r_prescale   <= '0;
            r_pre_cnt    <= '0;
            r_mtime      <= '0;
            r_intr_state <= '0;
            r_intr_en    <= '0;
            r_cfg_en     <= '0;
            r_cfg_per    <= '0;
            r_rvalid     <= 1'b0;
            r_err        <= 1'b0;
            r_rdata      <= '0;
            for (int c = 0; c < NumChannels; c++) begin
                r_cmp[c]    <= '0;
                r_period[c] <= '0;
            end
        end else begin
            r_rvalid <= timer_req_i;
            r_err    <= timer_req_i && w_err;
            r_rdata  <= (timer_req_i && !timer_we_i && !w_err) ? w_rdata : '0;

            if (w_wr && w_idx == IDX_CTRL && timer_be_i[0]) begin
                r_ctrl_en <= timer_wdata_i[0];
            end

            if (w_wr && w_idx == IDX_PRESCALE) begin
                r_prescale <= w_prescale_m[15:0];
                r_pre_cnt  <= '0;
            end else if (r_ctrl_en) begin
                r_pre_cnt <= w_tick ? 16'h0 : r_pre_cnt + 16'h1;
            end

            // A software write to either half wins over the tick for the whole counter.
            if (w_wr && (w_idx == IDX_MTIME_LO || w_idx == IDX_MTIME_HI)) begin
                if (w_idx == IDX_MTIME_LO) begin
                    r_mtime[31:0] <= f_merge(r_mtime[31:0], timer_wdata_i, timer_be_i);
                end else begin
                    r_mtime[63:32] <= f_merge(r_mtime[63:32], timer_wdata_i, timer_be_i);
                end
            end else if (w_tick) begin
                r_mtime <= r_mtime + 64'd1;
            end

            r_intr_state <= (r_intr_state & ~w_w1c) | w_fire;
            if (w_wr && w_idx == IDX_INTR_EN) begin
                r_intr_en <= w_ie_m[NumChannels-1:0];
            end

            for (int c = 0; c < NumChannels; c++) begin
                if (w_cmp_lo_wr[c]) begin
                    r_cmp[c][31:0] <= f_merge(r_cmp[c][31:0], timer_wdata_i, timer_be_i);
                end else if (w_cmp_hi_wr[c]) begin
                    r_cmp[c][63:32] <= f_merge(r_cmp[c][63:32], timer_wdata_i, timer_be_i);
                end else if (w_fire[c] && r_cfg_per[c]) begin
                    r_cmp[c] <= r_cmp[c] + {32'h0, r_period[c]};
                end

                if (w_period_wr[c]) begin
                    r_period[c] <= f_merge(r_period[c], timer_wdata_i, timer_be_i);
                end

                if (w_cfg_wr[c]) begin
                    r_cfg_en[c]  <= timer_wdata_i[0];
                    r_cfg_per[c] <= timer_wdata_i[1];
                end else if (w_fire[c] && !r_cfg_per[c]) begin
                    r_cfg_en[c] <= 1'b0;
                end
            end
        end
    end

    assign timer_rvalid_o = r_rvalid;
    assign timer_rdata_o  = r_rdata;
    assign timer_err_o    = r_err;
    assign timer_intr_o   = r_intr_state & r_intr_en;
    assign timer_irq_o    = |timer_intr_o;

    assign w_unused = ^{timer_addr_i[AddressWidth-1:10], timer_addr_i[1:0],
                        w_ie_m[31:NumChannels], w_clr[31:NumChannels], w_prescale_m[31:16]};

endmodule
